// File: rtl/stopwatch_display_scan.sv
// stopwatch_display_scan
//   Drives a 4-digit, common-anode, multiplexed 7-segment display from the
//   stopwatch BCD digits. The digits and the timeout flag are captured once
//   per scan frame, so a frame never mixes old and new digits. Each digit
//   slot starts with an anti-ghosting dead-time. The leading tens-of-seconds
//   zero can be blanked. The decimal point follows the seconds digit. The
//   whole display blinks while the captured timeout flag is set.
//
// Ports
//   clk_100mhz    system clock
//   rst_n         asynchronous active-low reset
//   time_sec_h    tens of seconds (BCD 0..5)
//   time_sec_l    seconds (BCD 0..9)
//   time_msec_h   tenths (BCD 0..9)
//   time_msec_l   hundredths (BCD 0..9)
//   time_out      timeout flag from the stopwatch
//   an            digit anodes, active low, an[0]=hundredths .. an[3]=tens of seconds
//   seg           segments {g,f,e,d,c,b,a}, active low
//   dp            decimal point, active low
//   frame_strobe  one-cycle pulse when a new digit snapshot is taken

module stopwatch_display_scan #(
  parameter int SCAN_DIV     = 100000,
  parameter int DEAD_CYCLES  = 100,
  parameter int BLINK_FRAMES = 125,
  parameter bit LZ_BLANK     = 1'b1
) (
  input  logic       clk_100mhz,
  input  logic       rst_n,
  input  logic [2:0] time_sec_h,
  input  logic [3:0] time_sec_l,
  input  logic [3:0] time_msec_h,
  input  logic [3:0] time_msec_l,
  input  logic       time_out,
  output logic [3:0] an,
  output logic [6:0] seg,
  output logic       dp,
  output logic       frame_strobe
);

  localparam int PW = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int CW = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [PW-1:0] PRE_LAST   = PW'(SCAN_DIV - 1);
  localparam logic [PW-1:0] DEAD_LIM   = PW'(DEAD_CYCLES);
  localparam logic [CW-1:0] BLINK_LAST = CW'(BLINK_FRAMES - 1);
  localparam logic [6:0]    SEG_DASH   = 7'b0111111;
  localparam logic [6:0]    SEG_OFF    = 7'b1111111;

  logic [PW-1:0] prescale_q, prescale_d;
  logic [1:0]    digitIdx_q, digitIdx_d;
  logic [2:0]    shadowSecH_q, shadowSecH_d;
  logic [3:0]    shadowSecL_q, shadowSecL_d;
  logic [3:0]    shadowMsecH_q, shadowMsecH_d;
  logic [3:0]    shadowMsecL_q, shadowMsecL_d;
  logic          shadowTimeOut_q, shadowTimeOut_d;
  logic [CW-1:0] blinkCnt_q, blinkCnt_d;
  logic          blinkPhase_q, blinkPhase_d;

  logic [3:0]    an_q, an_d;
  logic [6:0]    seg_q, seg_d;
  logic          dp_q, dp_d;
  logic          frameStrobe_q, frameStrobe_d;

  logic          tick;
  logic          snapshot;
  logic [3:0]    digitCode;

  // Plain BCD-to-segment lookup; anything above 9 shows a dash.
  function automatic logic [6:0] decodeDigit(input logic [3:0] d);
    case (d)
      4'd0:    decodeDigit = 7'b1000000;
      4'd1:    decodeDigit = 7'b1111001;
      4'd2:    decodeDigit = 7'b0100100;
      4'd3:    decodeDigit = 7'b0110000;
      4'd4:    decodeDigit = 7'b0011001;
      4'd5:    decodeDigit = 7'b0010010;
      4'd6:    decodeDigit = 7'b0000010;
      4'd7:    decodeDigit = 7'b1111000;
      4'd8:    decodeDigit = 7'b0000000;
      4'd9:    decodeDigit = 7'b0010000;
      default: decodeDigit = SEG_DASH;
    endcase
  endfunction

  assign tick     = (prescale_q == PRE_LAST);
  assign snapshot = tick && (digitIdx_q == 2'd3);

  // Scan timing, frame snapshot and blink bookkeeping. The snapshot is taken
  // on the tick that wraps the digit index back to 0, so a new frame always
  // starts with fresh shadow digits. The blink state is updated in the same
  // cycle, which lets a cleared timeout make that very frame visible.
  always_comb begin
    prescale_d      = prescale_q + 1'b1;
    digitIdx_d      = digitIdx_q;
    shadowSecH_d    = shadowSecH_q;
    shadowSecL_d    = shadowSecL_q;
    shadowMsecH_d   = shadowMsecH_q;
    shadowMsecL_d   = shadowMsecL_q;
    shadowTimeOut_d = shadowTimeOut_q;
    blinkCnt_d      = blinkCnt_q;
    blinkPhase_d    = blinkPhase_q;

    if (tick) begin
      prescale_d = '0;
      digitIdx_d = digitIdx_q + 2'd1;
    end

    if (snapshot) begin
      shadowSecH_d    = time_sec_h;
      shadowSecL_d    = time_sec_l;
      shadowMsecH_d   = time_msec_h;
      shadowMsecL_d   = time_msec_l;
      shadowTimeOut_d = time_out;
      if (time_out) begin
        if (blinkCnt_q == BLINK_LAST) begin
          blinkCnt_d   = '0;
          blinkPhase_d = ~blinkPhase_q;
        end else begin
          blinkCnt_d = blinkCnt_q + 1'b1;
        end
      end else begin
        blinkCnt_d   = '0;
        blinkPhase_d = 1'b0;
      end
    end
  end

  // Output image for the current slot. seg and dp already show the new digit
  // during dead-time; only the anodes are held off then and during the dark
  // blink phase.
  always_comb begin
    an_d          = 4'b1111;
    seg_d         = SEG_OFF;
    dp_d          = 1'b1;
    frameStrobe_d = snapshot;
    digitCode     = shadowMsecL_q;

    case (digitIdx_q)
      2'd0:    digitCode = shadowMsecL_q;
      2'd1:    digitCode = shadowMsecH_q;
      2'd2:    digitCode = shadowSecL_q;
      default: digitCode = {1'b0, shadowSecH_q};
    endcase

    if (!blinkPhase_q && !(prescale_q < DEAD_LIM)) begin
      an_d = ~(4'b0001 << digitIdx_q);
    end

    seg_d = decodeDigit(digitCode);
    if (digitIdx_q == 2'd3) begin
      if (LZ_BLANK && (shadowSecH_q == 3'd0)) begin
        seg_d = SEG_OFF;
      end else if (shadowSecH_q > 3'd5) begin
        seg_d = SEG_DASH;
      end
    end

    dp_d = (digitIdx_q != 2'd2);
  end

  // Scan and snapshot state.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      prescale_q      <= '0;
      digitIdx_q      <= 2'd0;
      shadowSecH_q    <= 3'd0;
      shadowSecL_q    <= 4'd0;
      shadowMsecH_q   <= 4'd0;
      shadowMsecL_q   <= 4'd0;
      shadowTimeOut_q <= 1'b0;
      blinkCnt_q      <= '0;
      blinkPhase_q    <= 1'b0;
    end else begin
      prescale_q      <= prescale_d;
      digitIdx_q      <= digitIdx_d;
      shadowSecH_q    <= shadowSecH_d;
      shadowSecL_q    <= shadowSecL_d;
      shadowMsecH_q   <= shadowMsecH_d;
      shadowMsecL_q   <= shadowMsecL_d;
      shadowTimeOut_q <= shadowTimeOut_d;
      blinkCnt_q      <= blinkCnt_d;
      blinkPhase_q    <= blinkPhase_d;
    end
  end

  // Registered pin drivers; reset forces the display dark immediately.
  always_ff @(posedge clk_100mhz or negedge rst_n) begin
    if (!rst_n) begin
      an_q          <= 4'b1111;
      seg_q         <= SEG_OFF;
      dp_q          <= 1'b1;
      frameStrobe_q <= 1'b0;
    end else begin
      an_q          <= an_d;
      seg_q         <= seg_d;
      dp_q          <= dp_d;
      frameStrobe_q <= frameStrobe_d;
    end
  end

  assign an           = an_q;
  assign seg          = seg_q;
  assign dp           = dp_q;
  assign frame_strobe = frameStrobe_q;

endmodule

// File: tb/tb_stopwatch_display_scan.sv
// Testbench for stopwatch_display_scan.
//   Two instances run side by side on the same inputs, one with leading-zero
//   blanking and one without. Expected pins come from a cycle-count model:
//   the slot, the position inside the slot and the frame number are derived
//   arithmetically from the number of clock edges since reset. The blink phase
//   is derived from how many consecutive timeout frames have been captured.

module tb_stopwatch_display_scan;

  localparam int SCAN_DIV     = 4;
  localparam int DEAD_CYCLES  = 1;
  localparam int BLINK_FRAMES = 2;
  localparam int FRAME_LEN    = 4 * SCAN_DIV;
  localparam logic [6:0] DASH = 7'b0111111;
  localparam logic [6:0] DARK = 7'b1111111;

  logic       clk = 1'b0;
  logic       rstN;
  logic [2:0] secH;
  logic [3:0] secL, msecH, msecL;
  logic       timeOut;

  logic [3:0] anA, anB;
  logic [6:0] segA, segB;
  logic       dpA, dpB;
  logic       strobeA, strobeB;

  int total = 0;
  int bad   = 0;

  // model state
  int         edgeCount;
  int         toRun;
  logic [2:0] mSecH;
  logic [3:0] mSecL, mMsecH, mMsecL;
  logic [6:0] glyphTable [0:9] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                                   7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                                   7'b0000000, 7'b0010000};

  always #5 clk = ~clk;

  stopwatch_display_scan #(
    .SCAN_DIV(SCAN_DIV), .DEAD_CYCLES(DEAD_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES), .LZ_BLANK(1'b1)
  ) dut (
    .clk_100mhz(clk), .rst_n(rstN),
    .time_sec_h(secH), .time_sec_l(secL), .time_msec_h(msecH), .time_msec_l(msecL),
    .time_out(timeOut),
    .an(anA), .seg(segA), .dp(dpA), .frame_strobe(strobeA)
  );

  stopwatch_display_scan #(
    .SCAN_DIV(SCAN_DIV), .DEAD_CYCLES(DEAD_CYCLES),
    .BLINK_FRAMES(BLINK_FRAMES), .LZ_BLANK(1'b0)
  ) dutNoLz (
    .clk_100mhz(clk), .rst_n(rstN),
    .time_sec_h(secH), .time_sec_l(secL), .time_msec_h(msecH), .time_msec_l(msecL),
    .time_out(timeOut),
    .an(anB), .seg(segB), .dp(dpB), .frame_strobe(strobeB)
  );

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    total++;
    if (observed !== expected) begin
      bad++;
      $display("[TB] FAIL %s at %0t: got %0h expected %0h", tag, $time, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic [2:0] sh, input logic [3:0] sl,
                               input logic [3:0] mh, input logic [3:0] ml,
                               input logic to);
    secH    = sh;
    secL    = sl;
    msecH   = mh;
    msecL   = ml;
    timeOut = to;
  endtask

  task automatic modelReset();
    edgeCount = 0;
    toRun     = 0;
    mSecH     = 3'd0;
    mSecL     = 4'd0;
    mMsecH    = 4'd0;
    mMsecL    = 4'd0;
  endtask

  // One clock: expected pins for the state counted before this edge, then the
  // frame capture if this edge closes a frame.
  task automatic stepCycle();
    int         c, p, k, digit;
    logic [3:0] expAn;
    logic [6:0] expSegLz, expSegNoLz;
    logic       expDp, expStrobe, dark;
    @(posedge clk);
    #1;
    c = edgeCount;
    edgeCount++;
    p = c % SCAN_DIV;
    k = (c / SCAN_DIV) % 4;
    dark = ((toRun / BLINK_FRAMES) % 2) == 1;
    expAn = (dark || p < DEAD_CYCLES) ? 4'b1111 : ~(4'b0001 << k);
    case (k)
      0:       digit = int'(mMsecL);
      1:       digit = int'(mMsecH);
      2:       digit = int'(mSecL);
      default: digit = int'(mSecH);
    endcase
    if (k == 3) begin
      if (digit == 0) begin
        expSegLz   = DARK;
        expSegNoLz = glyphTable[0];
      end else if (digit > 5) begin
        expSegLz   = DASH;
        expSegNoLz = DASH;
      end else begin
        expSegLz   = glyphTable[digit];
        expSegNoLz = glyphTable[digit];
      end
    end else begin
      expSegLz   = (digit > 9) ? DASH : glyphTable[digit];
      expSegNoLz = expSegLz;
    end
    expDp     = (k == 2) ? 1'b0 : 1'b1;
    expStrobe = (c % FRAME_LEN) == (FRAME_LEN - 1);

    checkOutput("an", 32'(anA), 32'(expAn));
    checkOutput("seg", 32'(segA), 32'(expSegLz));
    checkOutput("dp", 32'(dpA), 32'(expDp));
    checkOutput("frame_strobe", 32'(strobeA), 32'(expStrobe));
    checkOutput("an_nolz", 32'(anB), 32'(expAn));
    checkOutput("seg_nolz", 32'(segB), 32'(expSegNoLz));

    if (expStrobe) begin
      mSecH  = secH;
      mSecL  = secL;
      mMsecH = msecH;
      mMsecL = msecL;
      toRun  = timeOut ? toRun + 1 : 0;
    end
  endtask

  task automatic runCycles(input int n);
    for (int i = 0; i < n; i++) stepCycle();
  endtask

  // Runs until the edge that captured a new frame has just passed.
  task automatic waitSnapshot();
    int guard;
    guard = 0;
    do begin
      stepCycle();
      guard++;
    end while ((edgeCount % FRAME_LEN) != 0 && guard < 2 * FRAME_LEN);
    if ((edgeCount % FRAME_LEN) != 0) checkOutput("snapshot_timeout", 32'(guard), 32'(FRAME_LEN));
  endtask

  initial begin
    rstN = 1'b1;
    applyStimulus(3'd3, 4'd7, 4'd4, 4'd2, 1'b0);
    #2 rstN = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_an", 32'(anA), 32'hF);
    checkOutput("reset_seg", 32'(segA), 32'h7F);
    checkOutput("reset_dp", 32'(dpA), 32'h1);
    checkOutput("reset_strobe", 32'(strobeA), 32'h0);
    modelReset();
    rstN = 1'b1;

    // first frame shows the reset shadow, second frame 37.42
    runCycles(2 * FRAME_LEN);

    // mid-frame change must wait for the next capture
    applyStimulus(3'd1, 4'd2, 4'd3, 4'd4, 1'b0);
    waitSnapshot();
    runCycles(FRAME_LEN / 2);
    applyStimulus(3'd5, 4'd9, 4'd9, 4'd9, 1'b0);
    runCycles(FRAME_LEN / 2 - 1);
    waitSnapshot();
    runCycles(FRAME_LEN);

    // invalid codes become dashes
    applyStimulus(3'd7, 4'd1, 4'd8, 4'hC, 1'b0);
    waitSnapshot();
    runCycles(FRAME_LEN);

    // leading zero on both instances
    applyStimulus(3'd0, 4'd0, 4'd5, 4'd6, 1'b0);
    waitSnapshot();
    runCycles(FRAME_LEN);

    // blink on timeout, then release
    applyStimulus(3'd2, 4'd3, 4'd0, 4'd1, 1'b1);
    runCycles(8 * FRAME_LEN);
    applyStimulus(3'd2, 4'd3, 4'd0, 4'd1, 1'b0);
    waitSnapshot();
    checkOutput("blink_cnt_cleared", 32'(dut.blinkCnt_q), 32'h0);
    checkOutput("blink_phase_cleared", 32'(dut.blinkPhase_q), 32'h0);
    runCycles(2 * FRAME_LEN);

    // asynchronous reset while slot 2 is lit
    for (int g = 0; g < 2 * FRAME_LEN && (edgeCount % FRAME_LEN) != 10; g++) stepCycle();
    checkOutput("pre_reset_dp", 32'(dpA), 32'h0);
    rstN = 1'b0;
    #1;
    checkOutput("midreset_an", 32'(anA), 32'hF);
    checkOutput("midreset_seg", 32'(segA), 32'h7F);
    checkOutput("midreset_dp", 32'(dpA), 32'h1);
    checkOutput("midreset_strobe", 32'(strobeA), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    modelReset();
    rstN = 1'b1;
    runCycles(3 * FRAME_LEN);

    // randomized traffic
    for (int i = 0; i < 1600; i++) begin
      if ($urandom_range(0, 7) == 0) secH = 3'($urandom_range(0, 7));
      if ($urandom_range(0, 7) == 0) secL = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 7) == 0) msecH = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 3) == 0) msecL = 4'($urandom_range(0, 15));
      if ($urandom_range(0, 63) == 0) timeOut = ~timeOut;
      stepCycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/stopwatch_display_scan.md
Name: stopwatch_display_scan

Overview:
- Drives a 4-digit, common-anode, multiplexed 7-segment display from the stopwatch counter's BCD outputs (sec_h, sec_l, msec_h, msec_l) and its time_out flag.
- Sits between the stopwatch control block and the board pins, and runs on the 100 MHz system clock.
- Snapshots the digits once per scan frame so no frame shows a mix of old and new digits, then time-multiplexes them.
- Adds a ghosting dead-time, leading-zero blanking, the decimal point, and blinking on timeout.

Parameters:
- SCAN_DIV, 100000: clk_100mhz cycles per digit slot (1 kHz digit rate, 250 Hz frame rate).
- DEAD_CYCLES, 100: cycles at the start of each slot with all anodes off; must be < SCAN_DIV.
- BLINK_FRAMES, 125: frames per blink half-period (0.5 s at defaults).
- LZ_BLANK, 1: 1 = blank sec_h when it is 0.

Ports:
- clk_100mhz  input  1  system clock.
- rst_n  input  1  asynchronous, active-low reset.
- time_sec_h  input  3  tens of seconds, BCD 0..5.
- time_sec_l  input  4  seconds, BCD 0..9.
- time_msec_h  input  4  tenths, BCD 0..9.
- time_msec_l  input  4  hundredths, BCD 0..9.
- time_out  input  1  timeout flag from the stopwatch.
- an  output  4  digit anodes, active low; an[0]=msec_l … an[3]=sec_h.
- seg  output  7  segments {g,f,e,d,c,b,a}, active low.
- dp  output  1  decimal point, active low.
- frame_strobe  output  1  one-cycle pulse when a new snapshot is taken.

Behaviour:
- Reset (async, rst_n=0):
  - an=4'b1111, seg=7'b1111111, dp=1, frame_strobe=0.
  - Prescaler=0, digit index=0, shadow digits=0, shadow time_out=0, blink counter=0, blink phase=0.
  - Release is synchronous to the clock edge; the first slot starts with prescaler=0.
- Prescaler:
  - Counts 0..SCAN_DIV-1, wraps to 0.
  - tick = (prescaler==SCAN_DIV-1).
- Digit index:
  - 2-bit, increments on tick, wraps 3->0.
- Snapshot:
  - On the tick that wraps the index 3->0, all four digits and time_out are latched into shadow registers.
  - frame_strobe=1 for that one cycle.
  - Inputs changing mid-frame never affect the frame in progress.
  - The first frame after reset displays the reset shadow (0).
- Output registration:
  - All outputs are registered and reflect the index/prescaler state with 1-cycle latency.
- Dead-time:
  - While prescaler < DEAD_CYCLES: an=1111.
  - seg and dp already hold the value of the new digit during dead-time.
- Active digit:
  - an = one-hot-low of index, i.e. index k drives an[k]=0.
- Decode (0..9):
  - 0:1000000, 1:1111001, 2:0100100, 3:0110000, 4:0011001
  - 5:0010010, 6:0000010, 7:1111000, 8:0000000, 9:0010000
- Invalid codes:
  - Digits >9, or sec_h >5, decode as a dash: 0111111.
- Leading-zero blanking:
  - If LZ_BLANK=1 and shadow sec_h==0, index 3 drives seg=1111111 with its anode still enabled.
  - sec_l is never blanked, so the display reads "0.00" at minimum.
- Decimal point:
  - dp=0 only when index==2 (after sec_l).
- Blink, when shadow time_out==1:
  - The blink counter increments on each snapshot.
  - At BLINK_FRAMES-1 the counter resets to 0 and the phase toggles.
  - Phase 1 forces an=1111 for the whole frame.
- Blink, when shadow time_out==0:
  - Counter=0 and phase=0, applied on the same snapshot.
  - The display is visible from that frame on.
- Reset mid-frame:
  - Outputs go dark immediately; the scan restarts at index 0.
- Widths:
  - Prescaler width is clog2(SCAN_DIV).
  - Blink counter width is clog2(BLINK_FRAMES).
  - No arithmetic on the digits; decode only.

Test Plan (SCAN_DIV=4, DEAD_CYCLES=1, BLINK_FRAMES=2 unless noted):
- Reset, then hold inputs sec=3,7 msec=4,2:
  - Frame 1 shows 0.00 with sec_h blank.
  - Frame 2 cycles an=1110/1101/1011/0111.
  - seg=0100100, 0011001, 1111000 (with dp=0), 0110000.
  - an=1111 on the first cycle of each slot.
- Change inputs from 1,2,3,4 to 5,9,9,9 mid-frame:
  - The current frame still shows 12.34.
  - 59.99 appears only after the next frame_strobe.
- Feed msec_l=4'hC and sec_h=3'd7:
  - seg=0111111 on the an[0] slot and on the an[3] slot.
- Set sec_h=0:
  - With LZ_BLANK=1, the slot-3 seg is 1111111.
  - With LZ_BLANK=0, the slot-3 seg is 1000000.
- Assert time_out=1:
  - Anodes are active for 2 frames, 1111 for 2 frames, then repeat.
  - Deassert: anodes are active from the next snapshot frame and the blink counter reads 0.
- Pulse rst_n low mid-slot on index 2:
  - an=1111, seg=1111111, dp=1 asynchronously.
  - After release, index 0 starts with a full dead-time.
